// File: rtl/fractal_sync_nd_node.sv
// ----------------------------------------------------------------------------
// fractal_sync_nd_node
//
// N-ary barrier aggregation node of the fractal synchronisation tree. Child
// arrivals are collected in a small barrier table. A barrier whose aggregate
// shows no level above this node wakes all children locally. Otherwise it is
// forwarded to the parent, and the children are woken when the parent answers.
//
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   req_valid_i/ready  per-child arrival handshake; at most one grant per cycle
//   req_id_i           packed child barrier ids   (slice i = child i)
//   req_aggr_i         packed child aggregates    (slice i = child i)
//   rsp_valid_o        wake pulse to every child (all-ones while broadcasting)
//   rsp_id_o           id of the barrier being woken (0 when idle)
//   req_out_*          upward request to the parent (valid/ready)
//   rsp_in_*           parent wake response (always accepted)
//   err_double_o       pulse: a child arrived twice at a collecting barrier
//   err_orphan_o       pulse: parent response matched no WAIT_UP entry
//
// Optional feature (define FRACTAL_SYNC_ND_PERF_EN):
//   perf_barriers_o    saturating count of wake broadcasts
//   perf_stall_o       saturating count of cycles with requests but no grant
// ----------------------------------------------------------------------------
module fractal_sync_nd_node #(
    parameter int N_CHILDREN = 4,
    parameter int ID_WIDTH   = 4,
    parameter int AGGR_WIDTH = 8,
    parameter int LVL_OFFSET = 0,
    parameter int N_ENTRIES  = 4
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic [N_CHILDREN-1:0]            req_valid_i,
    output logic [N_CHILDREN-1:0]            req_ready_o,
    input  logic [N_CHILDREN*ID_WIDTH-1:0]   req_id_i,
    input  logic [N_CHILDREN*AGGR_WIDTH-1:0] req_aggr_i,
    output logic [N_CHILDREN-1:0]            rsp_valid_o,
    output logic [ID_WIDTH-1:0]              rsp_id_o,
    output logic                             req_out_valid_o,
    input  logic                             req_out_ready_i,
    output logic [ID_WIDTH-1:0]              req_out_id_o,
    output logic [AGGR_WIDTH-1:0]            req_out_aggr_o,
    input  logic                             rsp_in_valid_i,
    input  logic [ID_WIDTH-1:0]              rsp_in_id_i,
    output logic                             err_double_o,
    output logic                             err_orphan_o
`ifdef FRACTAL_SYNC_ND_PERF_EN
    ,
    output logic [31:0]                      perf_barriers_o,
    output logic [31:0]                      perf_stall_o
`endif
);

    localparam int PTR_W = (N_CHILDREN > 1) ? $clog2(N_CHILDREN) : 1;
    localparam int ENT_W = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1;

    typedef enum logic [2:0] {
        ST_FREE,
        ST_COLLECT,
        ST_PEND_UP,
        ST_WAIT_UP,
        ST_WAKE
    } state_e;

    // Barrier table
    state_e                state_q [N_ENTRIES];
    logic [ID_WIDTH-1:0]   id_q    [N_ENTRIES];
    logic [AGGR_WIDTH-1:0] aggr_q  [N_ENTRIES];
    logic [N_CHILDREN-1:0] mask_q  [N_ENTRIES];

    logic [PTR_W-1:0]      rr_ptr_q;
    logic                  err_double_q;
    logic                  err_orphan_q;
    logic                  up_lock_q;
    logic [ENT_W-1:0]      up_lock_idx_q;

    // Unpacked views of the child slices
    logic [ID_WIDTH-1:0]   child_id   [N_CHILDREN];
    logic [AGGR_WIDTH-1:0] child_aggr [N_CHILDREN];

    for (genvar c = 0; c < N_CHILDREN; c++) begin : g_slice
        assign child_id[c]   = req_id_i[c*ID_WIDTH +: ID_WIDTH];
        assign child_aggr[c] = req_aggr_i[c*AGGR_WIDTH +: AGGR_WIDTH];
    end

    // ------------------------------------------------------------------
    // Lowest-index FREE entry (allocation target)
    // ------------------------------------------------------------------
    logic             any_free;
    logic [ENT_W-1:0] free_idx;

    // NOTE: every always_comb output gets a default before any conditional
    // assignment, so no path leaves a value held and no latch is inferred.
    always_comb begin
        any_free = 1'b0;
        free_idx = '0;
        for (int e = N_ENTRIES - 1; e >= 0; e--) begin
            if (state_q[e] == ST_FREE) begin
                any_free = 1'b1;
                free_idx = ENT_W'(e);
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-child acceptability: join a collecting barrier, or open a new one
    // when the id is not busy anywhere in the table and a slot is free.
    // ------------------------------------------------------------------
    logic [N_CHILDREN-1:0] hit_collect;
    logic [N_CHILDREN-1:0] hit_any;
    logic [N_CHILDREN-1:0] acceptable;

    always_comb begin
        hit_collect = '0;
        hit_any     = '0;
        for (int c = 0; c < N_CHILDREN; c++) begin
            for (int e = 0; e < N_ENTRIES; e++) begin
                if (state_q[e] != ST_FREE && id_q[e] == child_id[c]) begin
                    hit_any[c] = 1'b1;
                    if (state_q[e] == ST_COLLECT) hit_collect[c] = 1'b1;
                end
            end
        end
        acceptable = hit_collect | (~hit_any & {N_CHILDREN{any_free}});
    end

    // ------------------------------------------------------------------
    // Round-robin arbiter starting at rr_ptr_q
    // ------------------------------------------------------------------
    logic                  grant_valid;
    logic [PTR_W-1:0]      grant_idx;
    logic [N_CHILDREN-1:0] grant_oh;
    logic [PTR_W-1:0]      rr_idx;
    int                    rr_cand;

    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        rr_cand     = 0;
        rr_idx      = '0;
        for (int k = 0; k < N_CHILDREN; k++) begin
            rr_cand = int'(rr_ptr_q) + k;
            if (rr_cand >= N_CHILDREN) rr_cand = rr_cand - N_CHILDREN;
            rr_idx = PTR_W'(rr_cand);
            if (!grant_valid && req_valid_i[rr_idx] && acceptable[rr_idx]) begin
                grant_valid = 1'b1;
                grant_idx   = rr_idx;
            end
        end
    end

    assign grant_oh    = grant_valid ? (N_CHILDREN'(1) << grant_idx) : '0;
    assign req_ready_o = grant_oh;

    // ------------------------------------------------------------------
    // Entry targeted by the granted child
    // ------------------------------------------------------------------
    logic [ID_WIDTH-1:0]   g_id;
    logic [AGGR_WIDTH-1:0] g_aggr;
    logic                  tgt_hit;
    logic [ENT_W-1:0]      tgt_idx;
    logic [N_CHILDREN-1:0] tgt_mask;
    logic [N_CHILDREN-1:0] new_mask;
    logic [AGGR_WIDTH-1:0] tgt_aggr;
    logic                  tgt_local;
    logic                  is_double;
    logic                  do_arrive;

    assign g_id   = child_id[grant_idx];
    assign g_aggr = child_aggr[grant_idx];

    always_comb begin
        tgt_hit = 1'b0;
        tgt_idx = free_idx;
        for (int e = 0; e < N_ENTRIES; e++) begin
            if (state_q[e] == ST_COLLECT && id_q[e] == g_id) begin
                tgt_hit = 1'b1;
                tgt_idx = ENT_W'(e);
            end
        end
        tgt_mask  = tgt_hit ? mask_q[tgt_idx] : '0;
        tgt_aggr  = tgt_hit ? aggr_q[tgt_idx] : g_aggr;
        new_mask  = tgt_mask | grant_oh;
        // Local when no level above this node is set in the aggregate
        tgt_local = (tgt_aggr >> (LVL_OFFSET + 1)) == '0;
        is_double = grant_valid && tgt_hit && ((tgt_mask & grant_oh) != '0);
        do_arrive = grant_valid && !is_double;
    end

    // ------------------------------------------------------------------
    // Upward, parent-response and wake selection
    // ------------------------------------------------------------------
    logic             up_valid;
    logic [ENT_W-1:0] up_idx;
    logic             par_hit;
    logic [ENT_W-1:0] par_idx;
    logic             wk_valid;
    logic [ENT_W-1:0] wk_idx;

    always_comb begin
        up_valid = 1'b0;
        up_idx   = '0;
        wk_valid = 1'b0;
        wk_idx   = '0;
        par_hit  = 1'b0;
        par_idx  = '0;
        for (int e = N_ENTRIES - 1; e >= 0; e--) begin
            if (state_q[e] == ST_PEND_UP) begin
                up_valid = 1'b1;
                up_idx   = ENT_W'(e);
            end
            if (state_q[e] == ST_WAKE) begin
                wk_valid = 1'b1;
                wk_idx   = ENT_W'(e);
            end
            if (state_q[e] == ST_WAIT_UP && id_q[e] == rsp_in_id_i) begin
                par_hit = 1'b1;
                par_idx = ENT_W'(e);
            end
        end
        // A request already offered but not taken stays on the bus even if a
        // lower-index entry becomes PEND_UP meanwhile.
        if (up_lock_q) begin
            up_valid = 1'b1;
            up_idx   = up_lock_idx_q;
        end
    end

    assign req_out_valid_o = up_valid;
    assign req_out_id_o    = up_valid ? id_q[up_idx]   : '0;
    assign req_out_aggr_o  = up_valid ? aggr_q[up_idx] : '0;
    assign rsp_valid_o     = wk_valid ? '1 : '0;
    assign rsp_id_o        = wk_valid ? id_q[wk_idx] : '0;
    assign err_double_o    = err_double_q;
    assign err_orphan_o    = err_orphan_q;

    // ------------------------------------------------------------------
    // State register. Each event targets an entry in a distinct state, so
    // the updates below never collide on the same entry.
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int e = 0; e < N_ENTRIES; e++) state_q[e] <= ST_FREE;
            rr_ptr_q      <= '0;
            err_double_q  <= 1'b0;
            err_orphan_q  <= 1'b0;
            up_lock_q     <= 1'b0;
            up_lock_idx_q <= '0;
        end else begin
            err_double_q  <= is_double;
            err_orphan_q  <= rsp_in_valid_i && !par_hit;
            up_lock_q     <= up_valid && !req_out_ready_i;
            up_lock_idx_q <= up_idx;

            if (grant_valid) begin
                rr_ptr_q <= (grant_idx == PTR_W'(N_CHILDREN - 1)) ? '0 : grant_idx + 1'b1;
            end
            if (do_arrive) begin
                if (&new_mask) state_q[tgt_idx] <= tgt_local ? ST_WAKE : ST_PEND_UP;
                else           state_q[tgt_idx] <= ST_COLLECT;
            end
            if (up_valid && req_out_ready_i) state_q[up_idx]  <= ST_WAIT_UP;
            if (rsp_in_valid_i && par_hit)   state_q[par_idx] <= ST_WAKE;
            // A freed entry is still WAKE this edge, so allocation cannot pick it.
            if (wk_valid)                    state_q[wk_idx]  <= ST_FREE;
        end
    end

    // NOTE: the table payload has no reset; state_q alone says whether an
    // entry is live, and every allocation overwrites id, aggr and mask.
    always_ff @(posedge clk_i) begin
        if (do_arrive) begin
            mask_q[tgt_idx] <= new_mask;
            if (!tgt_hit) begin
                id_q[tgt_idx]   <= g_id;
                aggr_q[tgt_idx] <= g_aggr;
            end
        end
    end

`ifdef FRACTAL_SYNC_ND_PERF_EN
    logic [31:0] perf_barriers_q;
    logic [31:0] perf_stall_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_barriers_q <= '0;
            perf_stall_q    <= '0;
        end else begin
            if (wk_valid && perf_barriers_q != '1) perf_barriers_q <= perf_barriers_q + 32'd1;
            if ((|req_valid_i) && !grant_valid && perf_stall_q != '1) perf_stall_q <= perf_stall_q + 32'd1;
        end
    end

    assign perf_barriers_o = perf_barriers_q;
    assign perf_stall_o    = perf_stall_q;
`endif

endmodule

// File: tb/tb_fractal_sync_nd_node.sv
// ----------------------------------------------------------------------------
// Directed testbench for fractal_sync_nd_node.
// Instance u_dut uses default parameters; u_dut_b uses N_ENTRIES=2 for the
// table-full scenario. Inputs change on the falling edge, outputs are
// sampled on the falling edge (or 1 ns after an input change).
// ----------------------------------------------------------------------------
module tb_fractal_sync_nd_node;

    logic clk_i = 1'b0;
    logic rst_ni;
    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    // Instance A (defaults)
    logic [3:0]  req_valid, req_ready, rsp_valid, rsp_id;
    logic [15:0] req_id;
    logic [31:0] req_aggr;
    logic        up_valid, up_ready, pin_valid, err_double, err_orphan;
    logic [3:0]  up_id, pin_id;
    logic [7:0]  up_aggr;

    // Instance B (two-entry table)
    logic [3:0]  b_valid, b_ready, b_rsp_valid, b_rsp_id;
    logic [15:0] b_id;
    logic [31:0] b_aggr;
    logic        b_up_valid, b_up_ready, b_pin_valid, b_err_double, b_err_orphan;
    logic [3:0]  b_up_id, b_pin_id;
    logic [7:0]  b_up_aggr;

    fractal_sync_nd_node u_dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_id_i(req_id), .req_aggr_i(req_aggr),
        .rsp_valid_o(rsp_valid), .rsp_id_o(rsp_id),
        .req_out_valid_o(up_valid), .req_out_ready_i(up_ready),
        .req_out_id_o(up_id), .req_out_aggr_o(up_aggr),
        .rsp_in_valid_i(pin_valid), .rsp_in_id_i(pin_id),
        .err_double_o(err_double), .err_orphan_o(err_orphan)
    );

    fractal_sync_nd_node #(.N_ENTRIES(2)) u_dut_b (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid_i(b_valid), .req_ready_o(b_ready),
        .req_id_i(b_id), .req_aggr_i(b_aggr),
        .rsp_valid_o(b_rsp_valid), .rsp_id_o(b_rsp_id),
        .req_out_valid_o(b_up_valid), .req_out_ready_i(b_up_ready),
        .req_out_id_o(b_up_id), .req_out_aggr_o(b_up_aggr),
        .rsp_in_valid_i(b_pin_valid), .rsp_in_id_i(b_pin_id),
        .err_double_o(b_err_double), .err_orphan_o(b_err_orphan)
    );

    task automatic clear_inputs();
        req_valid = '0; req_id = '0; req_aggr = '0; up_ready = 1'b0;
        pin_valid = 1'b0; pin_id = '0;
        b_valid = '0; b_id = '0; b_aggr = '0; b_up_ready = 1'b0;
        b_pin_valid = 1'b0; b_pin_id = '0;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
    endtask

    // Presents one arrival on instance A and waits (bounded) for its grant.
    // Returns at the falling edge after the accepting rising edge.
    task automatic send_req(input int c, input logic [3:0] id, input logic [7:0] aggr, output bit acc);
        req_valid[c] = 1'b1;
        req_id[c*4 +: 4] = id;
        req_aggr[c*8 +: 8] = aggr;
        acc = 1'b0;
        for (int n = 0; n < 8 && !acc; n++) begin
            #1 acc = req_ready[c];
            @(negedge clk_i);
        end
        req_valid[c] = 1'b0;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        clear_inputs();
        req_valid = 4'hF;
        #2;
        checks++; if (rsp_valid !== 4'h0) begin errors++; $display("FAIL reset_rsp_valid: got %h want 0", rsp_valid); end
        checks++; if (rsp_id !== 4'h0) begin errors++; $display("FAIL reset_rsp_id: got %h want 0", rsp_id); end
        checks++; if (up_valid !== 1'b0 || up_id !== 4'h0 || up_aggr !== 8'h00) begin errors++; $display("FAIL reset_req_out: got v=%b id=%h aggr=%h want 0", up_valid, up_id, up_aggr); end
        checks++; if (err_double !== 1'b0 || err_orphan !== 1'b0) begin errors++; $display("FAIL reset_err: got %b%b want 00", err_double, err_orphan); end
        // Ready is combinational: with all FREE and pointer 0, child 0 wins
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL reset_ready: got %b want 0001", req_ready); end
        do_reset();
        checks++; if (rsp_valid !== 4'h0 || up_valid !== 1'b0) begin errors++; $display("FAIL reset_release: got rsp=%h up=%b want 0", rsp_valid, up_valid); end
    endtask

    task automatic test_local();
        bit acc;
        for (int c = 0; c < 4; c++) begin
            send_req(c, 4'd3, 8'h01, acc);
            checks++; if (acc !== 1'b1) begin errors++; $display("FAIL local_accept child %0d: got %b want 1", c, acc); end
            if (c < 3) begin
                checks++; if (rsp_valid !== 4'h0) begin errors++; $display("FAIL local_early_rsp child %0d: got %h want 0", c, rsp_valid); end
            end
        end
        checks++; if (rsp_valid !== 4'hF) begin errors++; $display("FAIL local_rsp_valid: got %h want F", rsp_valid); end
        checks++; if (rsp_id !== 4'd3) begin errors++; $display("FAIL local_rsp_id: got %h want 3", rsp_id); end
        checks++; if (up_valid !== 1'b0) begin errors++; $display("FAIL local_no_up: got %b want 0", up_valid); end
        @(negedge clk_i);
        checks++; if (rsp_valid !== 4'h0 || rsp_id !== 4'h0) begin errors++; $display("FAIL local_pulse_end: got %h/%h want 0/0", rsp_valid, rsp_id); end
    endtask

    task automatic test_upward();
        bit acc;
        for (int c = 0; c < 4; c++) begin
            send_req(c, 4'd5, 8'h03, acc);
            checks++; if (acc !== 1'b1) begin errors++; $display("FAIL up_accept child %0d: got %b want 1", c, acc); end
        end
        checks++; if (up_valid !== 1'b1 || up_id !== 4'd5 || up_aggr !== 8'h03) begin errors++; $display("FAIL up_req_out: got v=%b id=%h aggr=%h want 1/5/03", up_valid, up_id, up_aggr); end
        checks++; if (rsp_valid !== 4'h0) begin errors++; $display("FAIL up_no_local_wake: got %h want 0", rsp_valid); end
        // Hold ready low for 3 cycles; a parent response during PEND_UP is an orphan
        for (int i = 0; i < 3; i++) begin
            if (i == 0) begin pin_valid = 1'b1; pin_id = 4'd5; end
            @(negedge clk_i);
            pin_valid = 1'b0;
            checks++; if (up_valid !== 1'b1 || up_id !== 4'd5 || up_aggr !== 8'h03) begin errors++; $display("FAIL up_hold cycle %0d: got v=%b id=%h aggr=%h want 1/5/03", i, up_valid, up_id, up_aggr); end
            if (i < 2) begin
                checks++; if (err_orphan !== (i == 0)) begin errors++; $display("FAIL up_pend_orphan cycle %0d: got %b want %b", i, err_orphan, (i == 0)); end
            end
        end
        up_ready = 1'b1;
        #1;
        checks++; if (up_valid !== 1'b1) begin errors++; $display("FAIL up_valid_with_ready: got %b want 1", up_valid); end
        @(negedge clk_i);
        up_ready = 1'b0;
        checks++; if (up_valid !== 1'b0 || rsp_valid !== 4'h0) begin errors++; $display("FAIL up_after_hs: got up=%b rsp=%h want 0/0", up_valid, rsp_valid); end
        @(negedge clk_i);
        pin_valid = 1'b1; pin_id = 4'd5;
        @(negedge clk_i);
        pin_valid = 1'b0;
        checks++; if (rsp_valid !== 4'hF || rsp_id !== 4'd5) begin errors++; $display("FAIL up_wake: got %h/%h want F/5", rsp_valid, rsp_id); end
        checks++; if (err_orphan !== 1'b0) begin errors++; $display("FAIL up_wake_orphan: got %b want 0", err_orphan); end
        @(negedge clk_i);
        checks++; if (rsp_valid !== 4'h0) begin errors++; $display("FAIL up_wake_end: got %h want 0", rsp_valid); end
    endtask

    task automatic test_table_full();
        do_reset();
        b_aggr = {4{8'h01}};
        b_valid = 4'b0001; b_id = {4'd0, 4'd0, 4'd0, 4'd1}; #1;
        checks++; if (b_ready !== 4'b0001) begin errors++; $display("FAIL full_alloc1: got %b want 0001", b_ready); end
        @(negedge clk_i);
        b_valid = 4'b0010; b_id = {4'd0, 4'd0, 4'd1, 4'd0}; #1;
        checks++; if (b_ready !== 4'b0010) begin errors++; $display("FAIL full_join1: got %b want 0010", b_ready); end
        @(negedge clk_i);
        b_valid = 4'b0100; b_id = {4'd0, 4'd2, 4'd0, 4'd0}; #1;
        checks++; if (b_ready !== 4'b0100) begin errors++; $display("FAIL full_alloc2: got %b want 0100", b_ready); end
        @(negedge clk_i);
        b_valid = 4'b0001; b_id = {4'd0, 4'd0, 4'd0, 4'd7};
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (b_ready !== 4'b0000) begin errors++; $display("FAIL full_stall cycle %0d: got %b want 0000", i, b_ready); end
            @(negedge clk_i);
        end
        b_valid = 4'b0101; b_id = {4'd0, 4'd1, 4'd0, 4'd7}; #1;
        checks++; if (b_ready !== 4'b0100) begin errors++; $display("FAIL full_join_c2: got %b want 0100", b_ready); end
        @(negedge clk_i);
        b_valid = 4'b1001; b_id = {4'd1, 4'd0, 4'd0, 4'd7}; #1;
        checks++; if (b_ready !== 4'b1000) begin errors++; $display("FAIL full_join_c3: got %b want 1000", b_ready); end
        @(negedge clk_i);
        b_valid = 4'b0001; b_id = {4'd0, 4'd0, 4'd0, 4'd7}; #1;
        checks++; if (b_rsp_valid !== 4'hF || b_rsp_id !== 4'd1) begin errors++; $display("FAIL full_wake1: got %h/%h want F/1", b_rsp_valid, b_rsp_id); end
        checks++; if (b_ready !== 4'b0000) begin errors++; $display("FAIL full_no_same_edge_realloc: got %b want 0000", b_ready); end
        @(negedge clk_i);
        #1;
        checks++; if (b_ready !== 4'b0001 || b_rsp_valid !== 4'h0) begin errors++; $display("FAIL full_accept7: got ready=%b rsp=%h want 0001/0", b_ready, b_rsp_valid); end
        @(negedge clk_i);
        b_valid = '0;
    endtask

    task automatic test_round_robin();
        logic [3:0] exp;
        do_reset();
        req_valid = 4'hF;
        req_id    = {4'd11, 4'd10, 4'd9, 4'd8};
        req_aggr  = {4{8'h01}};
        for (int n = 0; n < 5; n++) begin
            exp = 4'b0001 << (n % 4);
            #1;
            checks++; if (req_ready !== exp) begin errors++; $display("FAIL rr_grant %0d: got %b want %b", n, req_ready, exp); end
            @(negedge clk_i);
        end
        // Fifth grant re-delivered child 0 to barrier 8
        checks++; if (err_double !== 1'b1) begin errors++; $display("FAIL rr_double: got %b want 1", err_double); end
        req_valid = '0;
        @(negedge clk_i);
        checks++; if (err_double !== 1'b0) begin errors++; $display("FAIL rr_double_end: got %b want 0", err_double); end
    endtask

    task automatic test_errors();
        bit acc;
        do_reset();
        send_req(2, 4'd4, 8'h01, acc);
        checks++; if (acc !== 1'b1 || err_double !== 1'b0) begin errors++; $display("FAIL err_first: got acc=%b dbl=%b want 1/0", acc, err_double); end
        send_req(2, 4'd4, 8'h01, acc);
        checks++; if (acc !== 1'b1) begin errors++; $display("FAIL err_double_accept: got %b want 1", acc); end
        checks++; if (err_double !== 1'b1) begin errors++; $display("FAIL err_double_pulse: got %b want 1", err_double); end
        @(negedge clk_i);
        checks++; if (err_double !== 1'b0) begin errors++; $display("FAIL err_double_end: got %b want 0", err_double); end
        send_req(0, 4'd4, 8'h01, acc);
        send_req(1, 4'd4, 8'h01, acc);
        checks++; if (rsp_valid !== 4'h0) begin errors++; $display("FAIL err_mask_kept: got %h want 0", rsp_valid); end
        send_req(3, 4'd4, 8'h01, acc);
        checks++; if (rsp_valid !== 4'hF || rsp_id !== 4'd4) begin errors++; $display("FAIL err_complete: got %h/%h want F/4", rsp_valid, rsp_id); end
        @(negedge clk_i);
        pin_valid = 1'b1; pin_id = 4'd9;
        @(negedge clk_i);
        pin_valid = 1'b0;
        checks++; if (err_orphan !== 1'b1 || rsp_valid !== 4'h0) begin errors++; $display("FAIL err_orphan: got %b rsp=%h want 1/0", err_orphan, rsp_valid); end
        @(negedge clk_i);
        checks++; if (err_orphan !== 1'b0) begin errors++; $display("FAIL err_orphan_end: got %b want 0", err_orphan); end
    endtask

    task automatic test_reset_mid();
        bit acc;
        do_reset();
        for (int c = 0; c < 3; c++) send_req(c, 4'd6, 8'h01, acc);
        rst_ni = 1'b0;
        #1;
        checks++; if (rsp_valid !== 4'h0 || rsp_id !== 4'h0 || up_valid !== 1'b0 || err_double !== 1'b0 || err_orphan !== 1'b0) begin
            errors++; $display("FAIL mid_reset_outputs: got rsp=%h id=%h up=%b err=%b%b want 0", rsp_valid, rsp_id, up_valid, err_double, err_orphan);
        end
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        checks++; if (rsp_valid !== 4'h0) begin errors++; $display("FAIL mid_no_rsp: got %h want 0", rsp_valid); end
        for (int c = 0; c < 4; c++) begin
            send_req(c, 4'd6, 8'h01, acc);
            checks++; if (acc !== 1'b1 || err_double !== 1'b0) begin errors++; $display("FAIL mid_round child %0d: got acc=%b dbl=%b want 1/0", c, acc, err_double); end
            if (c < 3) begin
                checks++; if (rsp_valid !== 4'h0) begin errors++; $display("FAIL mid_early_rsp child %0d: got %h want 0", c, rsp_valid); end
            end
        end
        checks++; if (rsp_valid !== 4'hF || rsp_id !== 4'd6) begin errors++; $display("FAIL mid_wake: got %h/%h want F/6", rsp_valid, rsp_id); end
        @(negedge clk_i);
    endtask

    initial begin
        test_reset();
        test_local();
        test_upward();
        test_table_full();
        test_round_robin();
        test_errors();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

endmodule
